// File: rtl/axis_scale_arb.sv
// axis_scale_arb: two AXI-Stream sources, round-robin arbitrated into a single
// scaled and saturated DAC sample stream with a one-cycle registered output.
module axis_scale_arb #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int OUT_WIDTH        = 14,
  parameter int SIGNED           = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_A_tdata,
  input  logic                        S_AXIS_A_tvalid,
  output logic                        S_AXIS_A_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_B_tdata,
  input  logic                        S_AXIS_B_tvalid,
  output logic                        S_AXIS_B_tready,
  input  logic [4:0]                  cfg_shift_a,
  input  logic [4:0]                  cfg_shift_b,
  input  logic [1:0]                  cfg_enable,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_SCALED_tdata,
  output logic                        M_AXIS_SCALED_tvalid,
  input  logic                        M_AXIS_SCALED_tready,
  output logic                        M_AXIS_SCALED_tuser,
  output logic [15:0]                 sat_count
);

  localparam int W = AXIS_TDATA_WIDTH;
  localparam logic [W-1:0] ONE   = W'(1);
  // Signed limits in W-bit two's complement; the minimum is the complement of the maximum.
  localparam logic [W-1:0] S_MAX = (ONE << (OUT_WIDTH - 1)) - ONE;
  localparam logic [W-1:0] S_MIN = ~S_MAX;
  // Wraps to all ones when OUT_WIDTH equals the bus width; doubles as the output mask.
  localparam logic [W-1:0] U_MAX = (ONE << OUT_WIDTH) - ONE;

  logic         ptr;       // last grant: 0 = A, 1 = B
  logic         out_free;
  logic         vld_a, vld_b;
  logic         grant_b;
  logic         acc_a, acc_b, acc;
  logic [W-1:0] sel_data;
  logic [4:0]   sel_shift;
  logic [W-1:0] shifted;
  logic [W-1:0] clamped;
  logic         sat_hit;

  assign out_free = ~M_AXIS_SCALED_tvalid | M_AXIS_SCALED_tready;
  assign vld_a    = cfg_enable[0] & S_AXIS_A_tvalid;
  assign vld_b    = cfg_enable[1] & S_AXIS_B_tvalid;

  // B wins when it is the only valid enabled source, or when both are valid and A was granted last.
  assign grant_b  = vld_b & (~vld_a | ~ptr);

  // Disabled sources are drained (ready every cycle out of reset); enabled ones wait for grant.
  assign S_AXIS_A_tready = ~rst & (cfg_enable[0] ? (~grant_b & out_free) : 1'b1);
  assign S_AXIS_B_tready = ~rst & (cfg_enable[1] ? ( grant_b & out_free) : 1'b1);

  assign acc_a = vld_a & S_AXIS_A_tready;
  assign acc_b = vld_b & S_AXIS_B_tready;
  assign acc   = acc_a | acc_b;

  // Select the winning beat, shift it, then clamp it to the DAC range.
  always_comb begin
    sel_data  = acc_b ? S_AXIS_B_tdata : S_AXIS_A_tdata;
    sel_shift = acc_b ? cfg_shift_b    : cfg_shift_a;
    shifted   = '0;
    clamped   = '0;
    sat_hit   = 1'b0;
    if (SIGNED != 0) begin
      shifted = $signed(sel_data) >>> sel_shift;
      if ($signed(shifted) > $signed(S_MAX)) begin
        clamped = S_MAX;
        sat_hit = 1'b1;
      end else if ($signed(shifted) < $signed(S_MIN)) begin
        clamped = S_MIN;
        sat_hit = 1'b1;
      end else begin
        clamped = shifted;
      end
    end else begin
      shifted = sel_data >> sel_shift;
      if (shifted > U_MAX) begin
        clamped = U_MAX;
        sat_hit = 1'b1;
      end else begin
        clamped = shifted;
      end
    end
  end

  // Output register, round-robin pointer and saturation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      M_AXIS_SCALED_tvalid <= 1'b0;
      M_AXIS_SCALED_tdata  <= '0;
      M_AXIS_SCALED_tuser  <= 1'b0;
      sat_count            <= '0;
      ptr                  <= 1'b1;
    end else begin
      if (out_free) begin
        M_AXIS_SCALED_tvalid <= acc;
        if (acc) begin
          M_AXIS_SCALED_tdata <= clamped & U_MAX;
          M_AXIS_SCALED_tuser <= acc_b;
        end
      end
      if (acc) begin
        ptr <= acc_b;
        if (sat_hit && (sat_count != 16'hFFFF)) begin
          sat_count <= sat_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_scale_arb.sv
// Directed testbench for axis_scale_arb with default parameters (32-bit bus, 14-bit signed output).
module tb_axis_scale_arb;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a_data, b_data;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [4:0]    shift_a, shift_b;
  logic [1:0]    enable;
  logic [W-1:0]  m_data;
  logic          m_valid, m_ready, m_user;
  logic [15:0]   sat_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_scale_arb #(
    .AXIS_TDATA_WIDTH(W),
    .OUT_WIDTH(14),
    .SIGNED(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .S_AXIS_A_tdata(a_data),
    .S_AXIS_A_tvalid(a_valid),
    .S_AXIS_A_tready(a_ready),
    .S_AXIS_B_tdata(b_data),
    .S_AXIS_B_tvalid(b_valid),
    .S_AXIS_B_tready(b_ready),
    .cfg_shift_a(shift_a),
    .cfg_shift_b(shift_b),
    .cfg_enable(enable),
    .M_AXIS_SCALED_tdata(m_data),
    .M_AXIS_SCALED_tvalid(m_valid),
    .M_AXIS_SCALED_tready(m_ready),
    .M_AXIS_SCALED_tuser(m_user),
    .sat_count(sat_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 2'b11; a_valid = 1'b1; b_valid = 1'b1; m_ready = 1'b1;
    a_data = 32'h0000_0123; b_data = 32'h0000_0456; shift_a = '0; shift_b = '0;
    tick(); tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b exp 0", m_valid); end
    n_cmp++; if (m_data !== 32'h0) begin n_err++; $display("FAIL reset_tdata got %h exp 0", m_data); end
    n_cmp++; if (m_user !== 1'b0) begin n_err++; $display("FAIL reset_tuser got %b exp 0", m_user); end
    n_cmp++; if (sat_count !== 16'h0) begin n_err++; $display("FAIL reset_sat got %h exp 0", sat_count); end
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready got %b exp 0", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got %b exp 0", m_valid); end
  endtask

  task automatic test_scale_positive();
    enable = 2'b01; shift_a = 5'd18; a_data = 32'h7FFF_FFFF; a_valid = 1'b1; m_ready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL pos_a_ready got %b exp 1", a_ready); end
    tick();
    a_valid = 1'b0;
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL pos_tvalid got %b exp 1", m_valid); end
    n_cmp++; if (m_data !== 32'h0000_1FFF) begin n_err++; $display("FAIL pos_tdata got %h exp 00001fff", m_data); end
    n_cmp++; if (m_user !== 1'b0) begin n_err++; $display("FAIL pos_tuser got %b exp 0", m_user); end
    n_cmp++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL pos_sat got %0d exp 0", sat_count); end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL pos_idle got %b exp 0", m_valid); end
  endtask

  task automatic test_saturate();
    shift_a = 5'd16; a_data = 32'h8000_0000; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    n_cmp++; if (m_data !== 32'h0000_2000) begin n_err++; $display("FAIL neg_clamp_tdata got %h exp 00002000", m_data); end
    n_cmp++; if (sat_count !== 16'd1) begin n_err++; $display("FAIL neg_clamp_sat got %0d exp 1", sat_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  t_shift [7];
    logic [31:0] t_data  [7];
    logic [31:0] t_exp   [7];
    logic        t_clamp [7];
    logic [15:0] exp_sat;
    t_shift = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd31, 5'd31};
    t_data  = '{32'h0000_1FFF, 32'h0000_2000, 32'hFFFF_E000, 32'hFFFF_DFFF,
                32'hFFFF_F000, 32'h8000_0000, 32'h7FFF_FFFF};
    t_exp   = '{32'h0000_1FFF, 32'h0000_1FFF, 32'h0000_2000, 32'h0000_2000,
                32'h0000_3F00, 32'h0000_3FFF, 32'h0000_0000};
    t_clamp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_sat = 16'd1;
    for (int i = 0; i < 7; i++) begin
      shift_a = t_shift[i]; a_data = t_data[i]; a_valid = 1'b1;
      tick();
      if (t_clamp[i]) exp_sat = exp_sat + 16'd1;
      n_cmp++; if (m_valid !== 1'b1 || m_data !== t_exp[i]) begin
        n_err++; $display("FAIL b2b_beat%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, t_exp[i]);
      end
      n_cmp++; if (sat_count !== exp_sat) begin
        n_err++; $display("FAIL b2b_sat%0d got %0d exp %0d", i, sat_count, exp_sat);
      end
    end
    a_valid = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", m_valid); end
  endtask

  task automatic test_round_robin();
    logic exp_user;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 2'b11; shift_a = 5'd0; shift_b = 5'd1;
    a_data = 32'h0000_0100; b_data = 32'h0000_0400;
    a_valid = 1'b1; b_valid = 1'b1; m_ready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_err++; $display("FAIL rr_first_grant got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_user = (i % 2) != 0;
      n_cmp++; if (m_valid !== 1'b1 || m_user !== exp_user) begin
        n_err++; $display("FAIL rr_beat%0d got v=%b u=%b exp v=1 u=%b", i, m_valid, m_user, exp_user);
      end
      n_cmp++; if (m_data !== (exp_user ? 32'h0000_0200 : 32'h0000_0100)) begin
        n_err++; $display("FAIL rr_data%0d got %h exp %h", i, m_data, exp_user ? 32'h200 : 32'h100);
      end
    end
  endtask

  task automatic test_stall();
    m_ready = 1'b0;
    a_data = 32'h0000_0111; b_data = 32'h0000_0222;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_ready%0d got a=%b b=%b exp 0 0", i, a_ready, b_ready);
      end
      tick();
      n_cmp++; if (m_valid !== 1'b1 || m_user !== 1'b1 || m_data !== 32'h0000_0200) begin
        n_err++; $display("FAIL stall_hold%0d got v=%b u=%b d=%h exp v=1 u=1 d=00000200", i, m_valid, m_user, m_data);
      end
    end
    m_ready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_ptr got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
    end
    tick();
    n_cmp++; if (m_user !== 1'b0 || m_data !== 32'h0000_0111) begin
      n_err++; $display("FAIL stall_release got u=%b d=%h exp u=0 d=00000111", m_user, m_data);
    end
  endtask

  task automatic test_disabled();
    enable = 2'b01; a_valid = 1'b0; b_valid = 1'b1;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL dis_b_ready got %b exp 1", b_ready); end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL dis_discard got %b exp 0", m_valid); end
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = 32'h0000_0010 + 32'(i);
      #1;
      n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
        n_err++; $display("FAIL dis_ready%0d got a=%b b=%b exp 1 1", i, a_ready, b_ready);
      end
      tick();
      n_cmp++; if (m_valid !== 1'b1 || m_user !== 1'b0 || m_data !== 32'h0000_0010 + 32'(i)) begin
        n_err++; $display("FAIL dis_a_beat%0d got v=%b u=%b d=%h exp v=1 u=0 d=%h", i, m_valid, m_user, m_data, 32'h10 + 32'(i));
      end
    end
  endtask

  task automatic test_enable_drain();
    m_ready = 1'b0;
    enable = 2'b00;
    a_data = 32'h0000_0777; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_err++; $display("FAIL off_ready got a=%b b=%b exp 1 1", a_ready, b_ready);
    end
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'h0000_0012) begin
      n_err++; $display("FAIL off_hold got v=%b d=%h exp v=1 d=00000012", m_valid, m_data);
    end
    m_ready = 1'b1;
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL off_drain got %b exp 0", m_valid); end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL off_idle got %b exp 0", m_valid); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    enable = 2'b01; shift_a = 5'd0; a_data = 32'h7FFF_FFFF; a_valid = 1'b1; m_ready = 1'b1;
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'h0000_1FFF || sat_count !== 16'd1) begin
      n_err++; $display("FAIL rmid_pre got v=%b d=%h s=%0d exp v=1 d=00001fff s=1", m_valid, m_data, sat_count);
    end
    m_ready = 1'b0; enable = 2'b11; b_valid = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_ready got a=%b b=%b exp 0 0", a_ready, b_ready);
    end
    tick();
    n_cmp++; if (m_valid !== 1'b0 || sat_count !== 16'd0 || m_data !== 32'h0) begin
      n_err++; $display("FAIL rmid_clear got v=%b s=%0d d=%h exp v=0 s=0 d=0", m_valid, sat_count, m_data);
    end
    rst = 1'b0; m_ready = 1'b1;
    a_data = 32'h0000_0005; b_data = 32'h0000_0006; shift_b = 5'd0;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_grant got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
    end
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_user !== 1'b0 || m_data !== 32'h0000_0005) begin
      n_err++; $display("FAIL rmid_first got v=%b u=%b d=%h exp v=1 u=0 d=00000005", m_valid, m_user, m_data);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_scale_positive();
    test_saturate();
    test_back_to_back();
    test_round_robin();
    test_stall();
    test_disabled();
    test_enable_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_scale_arb.md
AXIS_SCALE_ARB -- requirements
Module: axis_scale_arb

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, SHALL set the bus width of all tdata ports.
REQ-002 Parameter OUT_WIDTH, default 14, SHALL set the DAC sample width (2..AXIS_TDATA_WIDTH).
REQ-003 Parameter SIGNED, default 1, SHALL select two's-complement (1) or unsigned (0) arithmetic.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Ports S_AXIS_A_tdata / S_AXIS_A_tvalid / S_AXIS_A_tready: input, input, output; AXIS_TDATA_WIDTH, 1, 1; stream A.
REQ-008 Ports S_AXIS_B_tdata / S_AXIS_B_tvalid / S_AXIS_B_tready: input, input, output; AXIS_TDATA_WIDTH, 1, 1; stream B.
REQ-009 Port cfg_shift_a, input, 5 bits: right-shift amount for A; cfg_shift_b, input, 5 bits: the same for B.
REQ-010 Port cfg_enable, input, 2 bits: bit0 enables A, bit1 enables B.
REQ-011 Ports M_AXIS_SCALED_tdata / _tvalid / _tready: output, output, input; AXIS_TDATA_WIDTH, 1, 1; scaled output to the DAC.
REQ-012 Port M_AXIS_SCALED_tuser, output, 1 bit: source channel of the current beat (0 = A, 1 = B).
REQ-013 Port sat_count, output, 16 bits: number of saturated beats.

Function
REQ-014 A beat SHALL be accepted from a source only when its tvalid and tready are both 1 in the same cycle.
REQ-015 The output register SHALL be "free" when M_AXIS_SCALED_tvalid=0 or M_AXIS_SCALED_tready=1.
REQ-016 An enabled source SHALL see tready=1 only when it holds the grant and the output register is free.
REQ-017 A disabled source SHALL see tready=1 every cycle out of reset, and its beats SHALL be discarded.
REQ-018 Arbitration SHALL be round-robin through a 1-bit last-grant pointer.
REQ-019 When both enabled sources are valid, the source not named by the pointer SHALL win.
REQ-020 When only one enabled source is valid, that source SHALL win.
REQ-021 The pointer SHALL update only on an accepted beat and SHALL never move on a stall.
REQ-022 Scaling SHALL shift the accepted tdata right by the shift input sampled in the accept cycle.
- SIGNED=1: arithmetic shift.
- SIGNED=0: logical shift.
REQ-023 The shifted value SHALL then be saturated to OUT_WIDTH bits.
- SIGNED=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- SIGNED=0: clamp to [0, 2^OUT_WIDTH-1].
REQ-024 The result SHALL be right-justified in M_AXIS_SCALED_tdata[OUT_WIDTH-1:0], with the upper bits forced to 0.
REQ-025 Latency SHALL be exactly 1 cycle from accept to M_AXIS_SCALED_tvalid=1, with tdata and tuser registered alongside.
REQ-026 Throughput SHALL be 1 beat per cycle while M_AXIS_SCALED_tready=1.
REQ-027 While M_AXIS_SCALED_tvalid=1 and M_AXIS_SCALED_tready=0, tdata, tuser and tvalid SHALL hold stable.
REQ-028 If no beat is accepted while the output register is free, M_AXIS_SCALED_tvalid SHALL fall to 0 on the next edge.
REQ-029 sat_count SHALL increment by 1 for each accepted beat that was clamped.
REQ-030 sat_count SHALL stick at 16'hFFFF and never wrap.
REQ-031 Changing cfg_enable or cfg_shift_* mid-stream SHALL affect only beats accepted after the change.
- A beat already in the output register SHALL be unaffected.
REQ-032 With cfg_enable=2'b00, the output SHALL drain its pending beat and then idle with tvalid=0.

Reset
REQ-033 While rst=1, the following SHALL hold at the next edge:
- M_AXIS_SCALED_tvalid=0, M_AXIS_SCALED_tdata=0, M_AXIS_SCALED_tuser=0.
- sat_count=0; pointer=1 (so A wins first).
- S_AXIS_A_tready=0, S_AXIS_B_tready=0.
REQ-034 Reset asserted mid-operation SHALL discard the pending output beat; no beat SHALL be accepted in any cycle where rst=1.

Verification
REQ-035 SIGNED=1, OUT_WIDTH=14, shift_a=18, A tdata=32'h7FFF_FFFF, M ready=1 -> next cycle tdata=32'h0000_1FFF, tuser=0, sat_count=0.
REQ-036 shift_a=16, A tdata=32'h8000_0000 -> tdata=32'h0000_2000 (clamped to -8192), sat_count=1.
REQ-037 Both enabled, both tvalid held high, M ready=1 -> tuser sequence 0,1,0,1 with one beat per cycle after reset.
REQ-038 M ready=0 for 3 cycles with a beat pending -> tdata, tuser and tvalid stable; both source treadys=0; pointer unchanged.
REQ-039 cfg_enable=2'b01, B tvalid=1 -> S_AXIS_B_tready=1 every cycle, no tuser=1 beats, A unaffected.
REQ-040 rst pulsed while M tvalid=1 -> tvalid=0 and sat_count=0 next cycle; the first grant after reset goes to A.
